simple_adder_seq_sv: RTL
========================

Name: simple_adder_seq_sv

Overview:
- Sequencing stage directly upstream of the W-bit combinational adder.
- Accepts a stream of operand words over a valid/ready handshake and pairs consecutive words into x_0 and x_1.
- Drives both operands into the adder from registers, captures the adder's sum plus a derived carry, and presents them downstream over a valid/ready handshake.
- Keeps a count of completed additions.

Parameters:
- W, 8, operand/result width in bits (must match the adder's W).
- CW, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- in_data  input  W  operand word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept an operand this cycle.
- add_x_0  output  W  registered first operand, wired to adder x_0.
- add_x_1  output  W  registered second operand, wired to adder x_1.
- add_result  input  W  adder sum (combinational from add_x_0/add_x_1).
- out_data  output  W  registered sum.
- out_carry  output  1  unsigned carry-out of the addition.
- out_valid  output  1  out_data/out_carry valid.
- out_ready  input  1  downstream accepts result.
- op_cnt  output  CW  number of results handed off, modulo 2^CW.

Behaviour:
- Reset (resetn=0, asynchronous, immediate): state=LOAD0; add_x_0, add_x_1, out_data=0; out_carry=0; out_valid=0; op_cnt=0; in_ready=0 while resetn=0.
- FSM states: LOAD0, LOAD1, CALC, HOLD.
- LOAD0: in_ready=1. On in_valid&in_ready, add_x_0<=in_data and go to LOAD1.
- LOAD1: in_ready=1. On in_valid&in_ready, add_x_1<=in_data and go to CALC.
- CALC: in_ready=0, lasts exactly one cycle.
  - out_data<=add_result.
  - out_carry<=(add_result < add_x_0), an unsigned compare equal to the true carry of add_x_0+add_x_1.
  - out_valid<=1; go to HOLD.
- HOLD: in_ready=0; out_valid=1.
  - out_data and out_carry stay stable until handshake.
  - On out_valid&out_ready: out_valid<=0, op_cnt<=op_cnt+1 (wraps 2^CW-1 -> 0), go to LOAD0.
  - No handshake: stay in HOLD indefinitely.
- Latency: second operand accepted at edge N -> out_valid=1 after edge N+1. Minimum period per operation is 4 cycles (LOAD0, LOAD1, CALC, HOLD with out_ready=1).
- in_valid=1 with in_ready=0 (CALC/HOLD): word not consumed; upstream holds it.
- add_x_0/add_x_1 hold their values through CALC and HOLD; they change only on operand accept.
- Arithmetic is modulo 2^W. The only overflow indication is out_carry.
- in_valid low in LOAD0/LOAD1: remain in state; no register changes.
- out_ready high outside HOLD: ignored.
- Reset asserted mid-operation (any state): all state returns to reset values immediately. A partially loaded pair is discarded and the pending result is lost, not counted.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- W=8, resetn released. Send 3 then 4 with in_valid held high, out_ready=1.
  -> add_x_0=3, add_x_1=4; out_data=7, out_carry=0.
  -> out_valid rises one cycle after 4 is accepted; op_cnt=1.
- Send 200 then 100.
  -> out_data=44, out_carry=1.
- Send 255 then 1.
  -> out_data=0, out_carry=1.
- Backpressure: after result 10+20, hold out_ready=0 for 5 cycles with in_valid=1 and in_data changing.
  -> out_valid stays 1, out_data stays 30, in_ready stays 0, no operand consumed.
  -> Raise out_ready: one handshake; op_cnt increments once; return to LOAD0.
- Reset mid-op: accept x_0=9, pull resetn low for 1 cycle (asynchronously, between edges).
  -> Outputs zero immediately; state LOAD0.
  -> Next pair 1+2 yields out_data=3; op_cnt counts from 0.
- CW=2: complete 5 back-to-back additions.
  -> op_cnt sequence 1,2,3,0,1.
  -> Check out_valid never asserts in LOAD0/LOAD1/CALC, and in_ready is never 1 in CALC/HOLD.

Source files
------------

// File: rtl/simple_adder_seq_sv.sv
// -----------------------------------------------------------------------------
// simple_adder_seq_sv
//
// Sequencing stage placed directly upstream of a W-bit combinational adder.
// Operand words arrive one at a time over a valid/ready handshake. Each
// consecutive pair of words becomes x_0 and x_1. The pair is held in registers
// that drive the adder. One cycle later the adder's sum and the carry-out are
// captured, then offered downstream over a second valid/ready handshake.
// A modulo-2^CW counter records how many results have been handed off.
//
// Ports:
//   clk         system clock, rising-edge active
//   resetn      asynchronous active-low reset
//   in_data     operand word (W bits)
//   in_valid    in_data is valid
//   in_ready    block accepts an operand this cycle (LOAD0/LOAD1 only)
//   add_x_0     registered first operand, to adder x_0
//   add_x_1     registered second operand, to adder x_1
//   add_result  adder sum, combinational from add_x_0/add_x_1
//   out_data    registered sum
//   out_carry   unsigned carry-out of add_x_0 + add_x_1
//   out_valid   out_data/out_carry valid
//   out_ready   downstream accepts the result
//   op_cnt      results handed off, modulo 2^CW
// -----------------------------------------------------------------------------
module simple_adder_seq_sv #(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [W-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  add_x_0,
    output logic [W-1:0]  add_x_1,
    input  logic [W-1:0]  add_result,
    output logic [W-1:0]  out_data,
    output logic          out_carry,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] op_cnt
);

    typedef enum logic [1:0] {
        LOAD0 = 2'd0,
        LOAD1 = 2'd1,
        CALC  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t        state_q,     state_d;
    logic [W-1:0]  add_x_0_q,   add_x_0_d;
    logic [W-1:0]  add_x_1_q,   add_x_1_d;
    logic [W-1:0]  out_data_q,  out_data_d;
    logic          out_carry_q, out_carry_d;
    logic          out_valid_q, out_valid_d;
    logic [CW-1:0] op_cnt_q,    op_cnt_d;

    logic in_accept;
    logic out_accept;

    // in_ready depends only on the state register and the reset pin, never on
    // in_valid. Gating with resetn keeps it low while the block is held in reset.
    assign in_ready   = resetn && ((state_q == LOAD0) || (state_q == LOAD1));
    assign in_accept  = in_valid && in_ready;
    assign out_accept = out_valid_q && out_ready;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so that no path
        // through the case leaves a value unassigned and infers a latch.
        state_d     = state_q;
        add_x_0_d   = add_x_0_q;
        add_x_1_d   = add_x_1_q;
        out_data_d  = out_data_q;
        out_carry_d = out_carry_q;
        out_valid_d = out_valid_q;
        op_cnt_d    = op_cnt_q;

        unique case (state_q)
            LOAD0: begin
                if (in_accept) begin
                    add_x_0_d = in_data;
                    state_d   = LOAD1;
                end
            end
            LOAD1: begin
                if (in_accept) begin
                    add_x_1_d = in_data;
                    state_d   = CALC;
                end
            end
            CALC: begin
                out_data_d  = add_result;
                // A modulo-2^W sum is smaller than an operand only if it wrapped.
                out_carry_d = (add_result < add_x_0_q);
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_accept) begin
                    out_valid_d = 1'b0;
                    op_cnt_d    = op_cnt_q + CW'(1);
                    state_d     = LOAD0;
                end
            end
            default: state_d = LOAD0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. Every flop then
    // samples its pre-edge inputs, whatever order the simulator evaluates in.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= LOAD0;
            add_x_0_q   <= '0;
            add_x_1_q   <= '0;
            out_data_q  <= '0;
            out_carry_q <= 1'b0;
            out_valid_q <= 1'b0;
            op_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            add_x_0_q   <= add_x_0_d;
            add_x_1_q   <= add_x_1_d;
            out_data_q  <= out_data_d;
            out_carry_q <= out_carry_d;
            out_valid_q <= out_valid_d;
            op_cnt_q    <= op_cnt_d;
        end
    end

    assign add_x_0   = add_x_0_q;
    assign add_x_1   = add_x_1_q;
    assign out_data  = out_data_q;
    assign out_carry = out_carry_q;
    assign out_valid = out_valid_q;
    assign op_cnt    = op_cnt_q;

endmodule
